// File: rtl/queue_line_sched_pkg.sv
// Shared definitions for the line-buffer scheduler and the conv datapath that sits beside it.
// Default image geometry, the scheduler state encoding and a constant clog2 helper.
package queue_line_sched_pkg;

  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam int K_DEF     = 3;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN,
    DONE
  } sched_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/queue_line_sched_if.sv
// Pixel-in / window-out handshake bundle of the line-buffer scheduler.
// master = scheduler side, slave = the surrounding pipeline (or a testbench).
interface queue_line_sched_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             in_vld;
  logic             in_rdy;
  logic             q_wr;
  logic             q_rd;
  logic             win_vld;
  logic             win_rdy;
  logic [CNT_W-1:0] win_row;
  logic [CNT_W-1:0] win_col;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, in_vld, win_rdy,
    output in_rdy, q_wr, q_rd, win_vld, win_row, win_col, busy, done, err
  );

  modport slave (
    output start, in_vld, win_rdy,
    input  in_rdy, q_wr, q_rd, win_vld, win_row, win_col, busy, done, err
  );
endinterface

// File: rtl/queue_line_sched_raster_cnt.sv
// Raster-order column/row counter for one frame; advances on inc, clears on clr.
module queue_line_sched_raster_cnt #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last_col,
  output logic             last_pix
);

  logic [CNT_W-1:0] col_reg;
  logic [CNT_W-1:0] row_reg;
  logic             last_row;

  assign last_col = (col_reg == CNT_W'(IMG_W - 1));
  assign last_row = (row_reg == CNT_W'(IMG_H - 1));
  assign last_pix = last_col & last_row;
  assign col      = col_reg;
  assign row      = row_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (clr) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (inc) begin
      if (last_col) begin
        col_reg <= '0;
        row_reg <= last_row ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/queue_line_sched.sv
// Line-buffer scheduler: drives the K-1 row queues from a raster pixel stream and
// publishes one window coordinate per legal KxK position, with downstream backpressure.
module queue_line_sched
  import queue_line_sched_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int K     = K_DEF,
  parameter int CNT_W = 5
) (
  input logic                clk,
  input logic                rst,
  queue_line_sched_if.master bus
);

  localparam int OCC_W = clog2(IMG_W + 1);

  sched_state_t     state_reg;
  logic [OCC_W-1:0] occ_reg;
  logic             win_vld_reg;
  logic [CNT_W-1:0] win_row_reg;
  logic [CNT_W-1:0] win_col_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;

  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic             last_col;
  logic             last_pix;
  logic             in_rdy;
  logic             accept;
  logic             q_rd;
  logic             occ_full;
  logic             win_hit;
  logic             win_hs;

  queue_line_sched_raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CNT_W (CNT_W)
  ) u_raster_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      ((state_reg == IDLE) && bus.start),
    .inc      (accept),
    .col      (col),
    .row      (row),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  // A pending window that is not being consumed blocks new pixels, so nothing is overwritten.
  assign in_rdy   = ((state_reg == FILL) || (state_reg == RUN)) && (!win_vld_reg || bus.win_rdy);
  assign accept   = bus.in_vld && in_rdy;
  assign occ_full = (occ_reg == OCC_W'(IMG_W));
  assign q_rd     = accept && occ_full;
  assign win_hit  = accept && (row >= CNT_W'(K - 1)) && (col >= CNT_W'(K - 1));
  assign win_hs   = win_vld_reg && bus.win_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (bus.start) begin
          state_reg <= FILL;
          busy_reg  <= 1'b1;
        end
        // Leave FILL once the counters roll onto (K-1, 0): the first K-1 rows are buffered.
        FILL: if (accept && last_col && (row == CNT_W'(K - 2))) state_reg <= RUN;
        RUN: if (accept && last_pix) state_reg <= DRAIN;
        DRAIN: if (win_hs) begin
          state_reg <= DONE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Queue occupancy; a simultaneous push and pop leaves it at IMG_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (accept && !q_rd) begin
        if (occ_full) err_reg <= 1'b1;
        else          occ_reg <= occ_reg + 1'b1;
      end
      if (q_rd && !accept) begin
        if (occ_reg == '0) err_reg <= 1'b1;
        else               occ_reg <= occ_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_vld_reg <= 1'b0;
      win_row_reg <= '0;
      win_col_reg <= '0;
    end else if (win_hit) begin
      win_vld_reg <= 1'b1;
      win_row_reg <= row - CNT_W'(K - 1);
      win_col_reg <= col - CNT_W'(K - 1);
    end else if (win_hs) begin
      win_vld_reg <= 1'b0;
    end
  end

  assign bus.in_rdy  = in_rdy;
  assign bus.q_wr    = accept;
  assign bus.q_rd    = q_rd;
  assign bus.win_vld = win_vld_reg;
  assign bus.win_row = win_row_reg;
  assign bus.win_col = win_col_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.err     = err_reg;

endmodule
